// File: rtl/button_event_decoder.sv
// ============================================================================
// Module   : button_event_decoder
// Purpose  : Turns a debounced button level into short, long and repeat pulses
//            and keeps a running count of short and long presses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_event_decoder #(
  parameter int LONG_CNT   = 8,
  parameter int REPEAT_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic [7:0] press_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HELD = 2'd1;
  localparam logic [1:0] LONG = 2'd2;

  localparam logic [15:0] LONG_LAST = 16'(LONG_CNT - 1);
  localparam logic [15:0] REP_LAST  = 16'(REPEAT_CNT - 1);

  logic [1:0]  state_q, state_d;
  logic        prev_in_q;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic [15:0] rep_cnt_q, rep_cnt_d;
  logic        short_q, short_d;
  logic        long_q, long_d;
  logic        repeat_q, repeat_d;
  logic [7:0]  count_q, count_d;
  logic        rise;

  assign rise = in && !prev_in_q;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    short_d    = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    count_d    = count_q;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d    = HELD;
          hold_cnt_d = 16'd0;
        end
      end

      HELD: begin
        if (!in) begin
          short_d = 1'b1;
          state_d = IDLE;
        end else if (hold_cnt_q >= LONG_LAST) begin
          long_d    = 1'b1;
          rep_cnt_d = 16'd0;
          state_d   = LONG;
        end else begin
          hold_cnt_d = hold_cnt_q + 16'd1;
        end
      end

      LONG: begin
        // Releasing after a long press is silent; the press was already counted.
        if (!in) begin
          state_d = IDLE;
        end else if (rep_cnt_q >= REP_LAST) begin
          repeat_d  = 1'b1;
          rep_cnt_d = 16'd0;
        end else begin
          rep_cnt_d = rep_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d    = IDLE;
        hold_cnt_d = 16'd0;
        rep_cnt_d  = 16'd0;
      end
    endcase

    // Counter moves in the same cycle the pulse becomes visible.
    if (short_d || long_d) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prev_in_q  <= 1'b0;
      hold_cnt_q <= 16'd0;
      rep_cnt_q  <= 16'd0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
      count_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      prev_in_q  <= in;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      short_q    <= short_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
      count_q    <= count_d;
    end
  end

  assign short_pulse  = short_q;
  assign long_pulse   = long_q;
  assign repeat_pulse = repeat_q;
  assign press_count  = count_q;

endmodule

`default_nettype wire
